// File: rtl/res_ttl_status_collector.sv
// -----------------------------------------------------------------------------
// res_ttl_status_collector
//
// Filters the per-channel "window passed" flags from the 8-channel TTL response
// checker over consecutive analysis windows into stable per-channel OK/FAIL
// verdicts. Each processed window produces one status report that is offered
// on a valid/ready handshake. Windows that arrive while a report is still
// being prepared or presented are dropped and counted.
//
// Optional feature macro: RES_TTL_STICKY_FAIL_EN
//   defined   : a channel FAIL verdict latches until rst and masks OK
//   undefined : FAIL follows the miss counter and recovers on a pass
//
// Parameters:
//   GOOD_WINDOWS  consecutive passing windows to declare OK   (1..15)
//   MISS_WINDOWS  consecutive failing windows to declare FAIL (1..15)
//
// Ports:
//   clk_100Mz               in   system clock
//   rst                     in   synchronous active-high reset
//   active_channel_res_ttl  in   [7:0] per-channel pass flags (sampled on strobe)
//   win_strobe              in   end-of-window pulse
//   chan_en                 in   [7:0] channel enable mask (sampled on strobe)
//   report_valid            out  report available
//   report_ready            in   consumer accepts report
//   report_ok               out  [7:0] per-channel OK verdict
//   report_fail             out  [7:0] per-channel FAIL verdict
//   report_seq              out  [7:0] report sequence number (wraps)
//   overrun_cnt             out  [7:0] dropped-window count (saturating)
//   all_ok                  out  all enabled channels OK, at least one enabled
// -----------------------------------------------------------------------------
module res_ttl_status_collector #(
  parameter int GOOD_WINDOWS = 4,
  parameter int MISS_WINDOWS = 2
) (
  input  logic       clk_100Mz,
  input  logic       rst,
  input  logic [7:0] active_channel_res_ttl,
  input  logic       win_strobe,
  input  logic [7:0] chan_en,
  output logic       report_valid,
  input  logic       report_ready,
  output logic [7:0] report_ok,
  output logic [7:0] report_fail,
  output logic [7:0] report_seq,
  output logic [7:0] overrun_cnt,
  output logic       all_ok
);

  localparam logic [3:0] GOOD_C = 4'(GOOD_WINDOWS);
  localparam logic [3:0] MISS_C = 4'(MISS_WINDOWS);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_UPDATE  = 2'd1,
    ST_PRESENT = 2'd2
  } state_t;

  state_t     r_state;
  logic [7:0] r_flags;
  logic [7:0] r_en;
  logic [3:0] r_good [8];
  logic [3:0] r_miss [8];

  logic [3:0] w_good_nxt [8];
  logic [3:0] w_miss_nxt [8];
  logic [7:0] w_ok_nxt;
  logic [7:0] w_fail_nxt;
  logic       w_all_ok_nxt;
  logic       w_accept;
  logic       w_drop;

  // Handshake completes only in PRESENT, where report_valid is always high.
  assign w_accept = (r_state == ST_PRESENT) && report_ready;
  // A strobe is lost if the block is busy and it is not absorbed by an accept.
  assign w_drop   = win_strobe &&
                    ((r_state == ST_UPDATE) || ((r_state == ST_PRESENT) && !report_ready));

  // Next per-channel counters and verdicts from the captured window.
  always_comb begin
    w_ok_nxt   = 8'h00;
    w_fail_nxt = 8'h00;
    for (int i = 0; i < 8; i++) begin
      w_good_nxt[i] = r_good[i];
      w_miss_nxt[i] = r_miss[i];
      if (!r_en[i]) begin
        w_good_nxt[i] = 4'd0;
        w_miss_nxt[i] = 4'd0;
      end else if (r_flags[i]) begin
        w_good_nxt[i] = (r_good[i] < GOOD_C) ? (r_good[i] + 4'd1) : GOOD_C;
        w_miss_nxt[i] = 4'd0;
      end else begin
        w_miss_nxt[i] = (r_miss[i] < MISS_C) ? (r_miss[i] + 4'd1) : MISS_C;
        w_good_nxt[i] = 4'd0;
      end
`ifdef RES_TTL_STICKY_FAIL_EN
      // Latched fail survives passes and disabled windows; it also masks OK.
      w_fail_nxt[i] = report_fail[i] | (r_en[i] & (w_miss_nxt[i] == MISS_C));
      w_ok_nxt[i]   = (w_good_nxt[i] == GOOD_C) & ~w_fail_nxt[i];
`else
      // Disabled channels have zeroed counters, so both verdicts read 0.
      w_fail_nxt[i] = (w_miss_nxt[i] == MISS_C);
      w_ok_nxt[i]   = (w_good_nxt[i] == GOOD_C);
`endif
    end
    w_all_ok_nxt = (&(w_ok_nxt | ~r_en)) & (|r_en);
  end

  // Control FSM, filter state and all registered report outputs.
  always_ff @(posedge clk_100Mz) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_flags      <= 8'h00;
      r_en         <= 8'h00;
      report_valid <= 1'b0;
      report_ok    <= 8'h00;
      report_fail  <= 8'h00;
      report_seq   <= 8'h00;
      overrun_cnt  <= 8'h00;
      all_ok       <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        r_good[i] <= 4'd0;
        r_miss[i] <= 4'd0;
      end
    end else begin
      if (w_drop && (overrun_cnt != 8'hFF)) begin
        overrun_cnt <= overrun_cnt + 8'd1;
      end
      case (r_state)
        ST_IDLE: begin
          if (win_strobe) begin
            r_flags <= active_channel_res_ttl;
            r_en    <= chan_en;
            r_state <= ST_UPDATE;
          end
        end
        ST_UPDATE: begin
          for (int i = 0; i < 8; i++) begin
            r_good[i] <= w_good_nxt[i];
            r_miss[i] <= w_miss_nxt[i];
          end
          report_ok    <= w_ok_nxt;
          report_fail  <= w_fail_nxt;
          all_ok       <= w_all_ok_nxt;
          report_seq   <= report_seq + 8'd1;
          report_valid <= 1'b1;
          r_state      <= ST_PRESENT;
        end
        ST_PRESENT: begin
          if (w_accept) begin
            report_valid <= 1'b0;
            if (win_strobe) begin
              // Back-to-back window: capture it in the accept cycle.
              r_flags <= active_channel_res_ttl;
              r_en    <= chan_en;
              r_state <= ST_UPDATE;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        default: begin
          report_valid <= 1'b0;
          r_state      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_res_ttl_status_collector.sv
// -----------------------------------------------------------------------------
// tb_res_ttl_status_collector
//
// Directed self-checking bench for res_ttl_status_collector with default
// parameters (GOOD_WINDOWS=4, MISS_WINDOWS=2). Expected values are hand
// computed; entries that depend on RES_TTL_STICKY_FAIL_EN are selected with
// the same macro.
// -----------------------------------------------------------------------------
module tb_res_ttl_status_collector;

  logic       clk_100Mz;
  logic       rst;
  logic [7:0] active_channel_res_ttl;
  logic       win_strobe;
  logic [7:0] chan_en;
  logic       report_valid;
  logic       report_ready;
  logic [7:0] report_ok;
  logic [7:0] report_fail;
  logic [7:0] report_seq;
  logic [7:0] overrun_cnt;
  logic       all_ok;

  int checks = 0;
  int errors = 0;

  res_ttl_status_collector #(
    .GOOD_WINDOWS(4),
    .MISS_WINDOWS(2)
  ) dut (
    .clk_100Mz             (clk_100Mz),
    .rst                   (rst),
    .active_channel_res_ttl(active_channel_res_ttl),
    .win_strobe            (win_strobe),
    .chan_en               (chan_en),
    .report_valid          (report_valid),
    .report_ready          (report_ready),
    .report_ok             (report_ok),
    .report_fail           (report_fail),
    .report_seq            (report_seq),
    .overrun_cnt           (overrun_cnt),
    .all_ok                (all_ok)
  );

  initial clk_100Mz = 1'b0;
  always #5 clk_100Mz = ~clk_100Mz;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) @(negedge clk_100Mz);
  endtask

  // Strobe one window; returns at the negedge after valid should rise.
  task automatic run_win(input logic [7:0] f, input logic [7:0] e);
    @(negedge clk_100Mz);
    active_channel_res_ttl = f;
    chan_en                = e;
    win_strobe             = 1'b1;
    @(negedge clk_100Mz);
    win_strobe = 1'b0;
    chk("valid_low_in_update", report_valid, 1'b0);
    @(negedge clk_100Mz);
    chk("valid_two_edges", report_valid, 1'b1);
  endtask

  task automatic chk_rep(input string tag, input logic [7:0] ok, input logic [7:0] fl,
                         input logic [7:0] seq, input logic aok);
    chk({tag, "_ok"},     report_ok,   ok);
    chk({tag, "_fail"},   report_fail, fl);
    chk({tag, "_seq"},    report_seq,  seq);
    chk({tag, "_all_ok"}, all_ok,      aok);
  endtask

  logic [7:0] exp_fail3;
  logic [7:0] exp_ok5  [6];
  logic [7:0] exp_fail5[6];
  logic       exp_aok5 [6];

  initial begin
`ifdef RES_TTL_STICKY_FAIL_EN
    exp_fail3 = 8'h08;
    exp_ok5   = '{8'hF6, 8'hF6, 8'hF6, 8'hF6, 8'hF6, 8'hF6};
    exp_fail5 = '{8'h08, 8'h09, 8'h09, 8'h09, 8'h09, 8'h09};
    exp_aok5  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`else
    exp_fail3 = 8'h00;
    exp_ok5   = '{8'hF6, 8'hFE, 8'hFE, 8'hFE, 8'hFE, 8'hFF};
    exp_fail5 = '{8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
    exp_aok5  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
`endif

    rst                    = 1'b1;
    win_strobe             = 1'b0;
    active_channel_res_ttl = 8'h00;
    chan_en                = 8'h00;
    report_ready           = 1'b1;
    idle(3);
    chk("rst_valid", report_valid, 1'b0);
    chk_rep("rst", 8'h00, 8'h00, 8'h00, 1'b0);
    chk("rst_ovr", overrun_cnt, 8'h00);
    rst = 1'b0;
    idle(2);

    // Basic pass: four all-pass windows, ready tied high.
    run_win(8'hFF, 8'hFF); chk_rep("pass1", 8'h00, 8'h00, 8'd1, 1'b0); idle(8);
    run_win(8'hFF, 8'hFF); chk_rep("pass2", 8'h00, 8'h00, 8'd2, 1'b0); idle(8);
    run_win(8'hFF, 8'hFF); chk_rep("pass3", 8'h00, 8'h00, 8'd3, 1'b0); idle(8);
    run_win(8'hFF, 8'hFF); chk_rep("pass4", 8'hFF, 8'h00, 8'd4, 1'b1); idle(8);
    chk("accepted_valid_low", report_valid, 1'b0);

    // Channel 3 misses twice.
    run_win(8'hF7, 8'hFF); chk_rep("miss1", 8'hF7, 8'h00, 8'd5, 1'b0); idle(4);
    run_win(8'hF7, 8'hFF); chk_rep("miss2", 8'hF7, 8'h08, 8'd6, 1'b0); idle(4);

    // Backpressure: three strobes while the report is held.
    report_ready = 1'b0;
    run_win(8'hFF, 8'hFF); chk_rep("bp", 8'hF7, exp_fail3, 8'd7, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_100Mz);
      active_channel_res_ttl = 8'h00;
      win_strobe             = 1'b1;
      @(negedge clk_100Mz);
      win_strobe = 1'b0;
    end
    idle(1);
    chk("bp_ovr", overrun_cnt, 8'd3);
    chk("bp_valid_held", report_valid, 1'b1);
    chk_rep("bp_hold", 8'hF7, exp_fail3, 8'd7, 1'b0);

    // Strobe coincident with the accept.
    @(negedge clk_100Mz);
    report_ready           = 1'b1;
    active_channel_res_ttl = 8'hFF;
    chan_en                = 8'hFF;
    win_strobe             = 1'b1;
    @(negedge clk_100Mz);
    win_strobe = 1'b0;
    chk("coinc_valid_low", report_valid, 1'b0);
    @(negedge clk_100Mz);
    chk("coinc_valid", report_valid, 1'b1);
    chk_rep("coinc", 8'hF7, exp_fail3, 8'd8, 1'b0);
    chk("coinc_ovr", overrun_cnt, 8'd3);
    idle(4);

    // Channel 0: two misses then four passes.
    for (int k = 0; k < 6; k++) begin
      run_win((k < 2) ? 8'hFE : 8'hFF, 8'hFF);
      chk_rep($sformatf("sticky%0d", k), exp_ok5[k], exp_fail5[k], 8'(9 + k), exp_aok5[k]);
      idle(4);
    end

    // Reset in the middle of a held report.
    report_ready = 1'b0;
    run_win(8'hFF, 8'hFF);
    chk("pre_rst_seq", report_seq, 8'd15);
    @(negedge clk_100Mz);
    rst = 1'b1;
    @(negedge clk_100Mz);
    chk("midrst_valid", report_valid, 1'b0);
    chk_rep("midrst", 8'h00, 8'h00, 8'h00, 1'b0);
    chk("midrst_ovr", overrun_cnt, 8'h00);
    rst          = 1'b0;
    report_ready = 1'b1;
    idle(2);

    // No channel enabled.
    run_win(8'hFF, 8'h00); chk_rep("en0_a", 8'h00, 8'h00, 8'd1, 1'b0); idle(4);
    run_win(8'h00, 8'h00); chk_rep("en0_b", 8'h00, 8'h00, 8'd2, 1'b0); idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
